// File: rtl/sad_pe_search.sv
// -----------------------------------------------------------------------------
// sad_pe_search
//
// Motion-estimation processing element. For each accepted pixel it takes the
// absolute difference between the reference pixel R and one of two search
// lanes (s1 or s2). It accumulates a saturating sum of absolute differences
// (SAD) over BLOCK_PIXELS pixels per candidate, for NUM_CANDS candidates per
// search. It keeps the smallest SAD seen in the search and the index of the
// candidate that produced it. R is re-registered onto Rpipe every cycle so that
// PEs can be chained into a systolic array.
//
// Optional build macro: ME_PE_SATFLAG_EN
//   When defined, the block adds the output sat_flag. sat_flag is registered
//   together with sad and is high when the reported candidate saturated at any
//   pixel. The SAD value is identical with or without the macro.
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   begin a new search in any state (the pixel in this cycle
//                     is discarded)
//   pix_valid    in   R/s1/s2/s1s2mux carry a pixel this cycle
//   R            in   reference pixel
//   s1, s2       in   search pixels, lanes 1 and 2
//   s1s2mux      in   1 selects s1, 0 selects s2
//   Rpipe        out  R delayed by one cycle
//   busy         out  high while accumulating
//   sad_valid    out  one-cycle pulse: sad/cand_idx/best_* describe a finished
//                     candidate
//   sad          out  SAD of the last finished candidate (held)
//   cand_idx     out  index of the last finished candidate (held)
//   best_sad     out  minimum SAD in the current search (all ones when empty)
//   best_idx     out  candidate index of best_sad
//   search_done  out  one-cycle pulse with the last candidate's sad_valid
//   sat_flag     out  (ME_PE_SATFLAG_EN only) the candidate saturated
//   o_dbg_state  out  FSM state: 0 IDLE, 1 ACCUM, 2 DONE
//
// Handshake: a pixel is consumed on a rising edge where the state is ACCUM,
// pix_valid=1 and start=0. There is no back-pressure. sad_valid and
// search_done are single-cycle strobes with no acknowledge.
// -----------------------------------------------------------------------------
module sad_pe_search #(
    parameter int PIXEL_W      = 8,
    parameter int ACC_W        = 16,
    parameter int BLOCK_PIXELS = 256,
    parameter int NUM_CANDS    = 16,
    parameter int CNT_W        = $clog2(BLOCK_PIXELS) + 1,
    parameter int IDX_W        = $clog2(NUM_CANDS) + 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               pix_valid,
    input  logic [PIXEL_W-1:0] R,
    input  logic [PIXEL_W-1:0] s1,
    input  logic [PIXEL_W-1:0] s2,
    input  logic               s1s2mux,
    output logic [PIXEL_W-1:0] Rpipe,
    output logic               busy,
    output logic               sad_valid,
    output logic [ACC_W-1:0]   sad,
    output logic [IDX_W-1:0]   cand_idx,
    output logic [ACC_W-1:0]   best_sad,
    output logic [IDX_W-1:0]   best_idx,
    output logic               search_done,
`ifdef ME_PE_SATFLAG_EN
    output logic               sat_flag,
`endif
    output logic [1:0]         o_dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(BLOCK_PIXELS - 1);
    localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NUM_CANDS - 1);

    logic [1:0]         r_state;
    logic [PIXEL_W-1:0] r_rpipe;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic [IDX_W-1:0]   r_cand_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_sad;
    logic [IDX_W-1:0]   r_cand_idx;
    logic [ACC_W-1:0]   r_best_sad;
    logic [IDX_W-1:0]   r_best_idx;
    logic               r_sad_valid;
    logic               r_search_done;

    logic [PIXEL_W-1:0] w_sel;
    logic [PIXEL_W:0]   w_diff_s;
    logic [PIXEL_W:0]   w_diff_mag;
    logic [ACC_W-1:0]   w_diff_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_first_pix;
    logic               w_last_pix;
    logic               w_last_cand;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_better;

    assign w_sel = s1s2mux ? s1 : s2;

    // (PIXEL_W+1)-bit two's-complement difference. Negate it when the result
    // is negative. The magnitude always fits in PIXEL_W bits.
    assign w_diff_s   = {1'b0, R} - {1'b0, w_sel};
    assign w_diff_mag = w_diff_s[PIXEL_W] ? (~w_diff_s + 1'b1) : w_diff_s;
    assign w_diff_ext = ACC_W'(w_diff_mag[PIXEL_W-1:0]);

    assign w_first_pix = (r_pix_cnt == '0);
    assign w_last_pix  = (r_pix_cnt == LAST_PIX);
    assign w_last_cand = (r_cand_cnt == LAST_CAND);

    // Add one bit of headroom so a carry out of ACC_W can be detected.
    // Once the accumulator saturates to all ones, any further non-zero
    // difference carries again. The value therefore stays pinned at the
    // maximum until the candidate ends.
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_diff_ext};
    assign w_carry    = !w_first_pix && w_sum[ACC_W];
    assign w_acc_next = w_first_pix ? w_diff_ext :
                        (w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0]);

    // Strict less-than, so ties keep the earlier candidate. Candidate 0
    // always seeds the best value.
    assign w_better = (r_cand_cnt == '0) || (w_acc_next < r_best_sad);

`ifdef ME_PE_SATFLAG_EN
    logic r_sat_acc;
    logic r_sat_flag;
    logic w_sat_next;

    // Sticky per-candidate saturation. It is cleared on the first pixel.
    assign w_sat_next = !w_first_pix && (r_sat_acc || w_carry);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_acc  <= 1'b0;
            r_sat_flag <= 1'b0;
        end else if (start) begin
            r_sat_acc <= 1'b0;
        end else if (r_state == ST_ACCUM && pix_valid) begin
            r_sat_acc <= w_sat_next;
            if (w_last_pix) begin
                r_sat_flag <= w_sat_next;
            end
        end
    end

    assign sat_flag = r_sat_flag;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_rpipe       <= '0;
            r_pix_cnt     <= '0;
            r_cand_cnt    <= '0;
            r_acc         <= '0;
            r_sad         <= '0;
            r_cand_idx    <= '0;
            r_best_sad    <= {ACC_W{1'b1}};
            r_best_idx    <= '0;
            r_sad_valid   <= 1'b0;
            r_search_done <= 1'b0;
        end else begin
            r_rpipe       <= R;
            r_sad_valid   <= 1'b0;
            r_search_done <= 1'b0;
            if (start) begin
                // Aborting a search emits no pulses. sad/cand_idx keep the
                // last completed result.
                r_state    <= ST_ACCUM;
                r_pix_cnt  <= '0;
                r_cand_cnt <= '0;
                r_acc      <= '0;
                r_best_sad <= {ACC_W{1'b1}};
                r_best_idx <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_ACCUM: begin
                        if (pix_valid) begin
                            r_acc <= w_acc_next;
                            if (w_last_pix) begin
                                r_pix_cnt   <= '0;
                                r_cand_cnt  <= r_cand_cnt + IDX_W'(1);
                                r_sad       <= w_acc_next;
                                r_cand_idx  <= r_cand_cnt;
                                r_sad_valid <= 1'b1;
                                if (w_better) begin
                                    r_best_sad <= w_acc_next;
                                    r_best_idx <= r_cand_cnt;
                                end
                                if (w_last_cand) begin
                                    r_state       <= ST_DONE;
                                    r_search_done <= 1'b1;
                                end
                            end else begin
                                r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Rpipe       = r_rpipe;
    assign busy        = (r_state == ST_ACCUM);
    assign sad_valid   = r_sad_valid;
    assign sad         = r_sad;
    assign cand_idx    = r_cand_idx;
    assign best_sad    = r_best_sad;
    assign best_idx    = r_best_idx;
    assign search_done = r_search_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sad_pe_search.sv
// -----------------------------------------------------------------------------
// tb_sad_pe_search
//
// Three instances of the block share the clock, the reset and the pixel
// buses. Each instance has its own start:
//   dut_a  default parameters: reset values and the Rpipe register
//   dut_b  BLOCK_PIXELS=4, NUM_CANDS=3: search, ties, lane select, gaps,
//          abort, and asynchronous reset
//   dut_c  ACC_W=8, BLOCK_PIXELS=4, NUM_CANDS=1: saturation
// The expected values are computed by hand from the pixel vectors.
// -----------------------------------------------------------------------------
module tb_sad_pe_search;

    logic       clock;
    logic       reset_n;
    logic       pix_valid;
    logic       s1s2mux;
    logic       start_a, start_b, start_c;
    logic [7:0] R, s1, s2;

    logic [7:0]  a_rpipe, b_rpipe, c_rpipe;
    logic        a_busy, b_busy, c_busy;
    logic        a_sv, b_sv, c_sv;
    logic [15:0] a_sad, a_best;
    logic [15:0] b_sad, b_best;
    logic [7:0]  c_sad, c_best;
    logic [4:0]  a_idx, a_bidx;
    logic [2:0]  b_idx, b_bidx;
    logic [0:0]  c_idx, c_bidx;
    logic        a_done, b_done, c_done;
    logic [1:0]  a_st, b_st, c_st;
`ifdef ME_PE_SATFLAG_EN
    logic        a_sat, b_sat, c_sat;
`endif

    int n_checks;
    int n_errors;

    sad_pe_search dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .pix_valid(pix_valid),
        .R(R), .s1(s1), .s2(s2), .s1s2mux(s1s2mux),
        .Rpipe(a_rpipe), .busy(a_busy), .sad_valid(a_sv), .sad(a_sad),
        .cand_idx(a_idx), .best_sad(a_best), .best_idx(a_bidx),
        .search_done(a_done),
`ifdef ME_PE_SATFLAG_EN
        .sat_flag(a_sat),
`endif
        .o_dbg_state(a_st)
    );

    sad_pe_search #(.BLOCK_PIXELS(4), .NUM_CANDS(3)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .pix_valid(pix_valid),
        .R(R), .s1(s1), .s2(s2), .s1s2mux(s1s2mux),
        .Rpipe(b_rpipe), .busy(b_busy), .sad_valid(b_sv), .sad(b_sad),
        .cand_idx(b_idx), .best_sad(b_best), .best_idx(b_bidx),
        .search_done(b_done),
`ifdef ME_PE_SATFLAG_EN
        .sat_flag(b_sat),
`endif
        .o_dbg_state(b_st)
    );

    sad_pe_search #(.ACC_W(8), .BLOCK_PIXELS(4), .NUM_CANDS(1)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start_c), .pix_valid(pix_valid),
        .R(R), .s1(s1), .s2(s2), .s1s2mux(s1s2mux),
        .Rpipe(c_rpipe), .busy(c_busy), .sad_valid(c_sv), .sad(c_sad),
        .cand_idx(c_idx), .best_sad(c_best), .best_idx(c_bidx),
        .search_done(c_done),
`ifdef ME_PE_SATFLAG_EN
        .sat_flag(c_sat),
`endif
        .o_dbg_state(c_st)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog");
    end

    // ---------------- check / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge. Outputs are sampled here and
    // inputs are changed here.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] r, input logic [7:0] a,
                            input logic [7:0] b, input logic m);
        R         = r;
        s1        = a;
        s2        = b;
        s1s2mux   = m;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b1;
        pix_valid = 1'b0;
        s1s2mux   = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        start_c   = 1'b0;
        R         = 8'd0;
        s1        = 8'd0;
        s2        = 8'd0;
        #2;
        reset_n = 1'b0;
        step();
        step();

        // Reset state of the default-parameter instance.
        check("rst_rpipe",    a_rpipe, 32'h0);
        check("rst_best_sad", a_best,  32'hFFFF);
        check("rst_busy",     a_busy,  32'h0);
        check("rst_sad_valid", a_sv,   32'h0);
        check("rst_done",     a_done,  32'h0);
        check("rst_sad",      a_sad,   32'h0);
        check("rst_state",    a_st,    32'h0);

        #3;
        reset_n = 1'b1;
        step();
        step();
        step();
        check("idle_best_sad", a_best, 32'hFFFF);
        check("idle_busy",     a_busy, 32'h0);
        check("idle_sv",       a_sv,   32'h0);
        check("idle_done",     a_done, 32'h0);

        // Rpipe follows R with one cycle of delay, even in IDLE.
        R = 8'hA5;
        step();
        check("rpipe_a5", a_rpipe, 32'hA5);
        R = 8'h00;

        // Pixels offered in IDLE are ignored.
        send_pix(8'd200, 8'd0, 8'd0, 1'b1);
        send_pix(8'd200, 8'd0, 8'd0, 1'b1);
        check("idle_pix_ignored_state", b_st, 32'h0);

        // ---------- dut_b: full search of 3 candidates ----------
        // The pixel presented with start is discarded.
        start_b   = 1'b1;
        R         = 8'd10;
        s1        = 8'd99;
        s1s2mux   = 1'b1;
        pix_valid = 1'b1;
        step();
        start_b   = 1'b0;
        pix_valid = 1'b0;
        check("b_busy_after_start", b_busy, 32'h1);
        check("b_state_accum", b_st, 32'h1);

        // Candidate 0: |10-3|+|10-12|+|10-10|+|10-0| = 7+2+0+10 = 19.
        send_pix(8'd10, 8'd3,  8'd0, 1'b1);
        send_pix(8'd10, 8'd12, 8'd0, 1'b1);
        send_pix(8'd10, 8'd10, 8'd0, 1'b1);
        check("c0_no_early_sv", b_sv, 32'h0);
        send_pix(8'd10, 8'd0,  8'd0, 1'b1);
        check("c0_sv",       b_sv,   32'h1);
        check("c0_sad",      b_sad,  32'd19);
        check("c0_idx",      b_idx,  32'd0);
        check("c0_best_sad", b_best, 32'd19);
        check("c0_best_idx", b_bidx, 32'd0);
        check("c0_done",     b_done, 32'h0);
        step();
        check("c0_sv_pulse", b_sv,  32'h0);
        check("c0_sad_held", b_sad, 32'd19);

        // Candidate 1: also 19, with gaps and a lane-2 pixel.
        // Pixels: 19 + 0 + 0 (s2) + 0.
        send_pix(8'd20, 8'd1, 8'd0, 1'b1);
        send_pix(8'd5,  8'd5, 8'd0, 1'b1);
        step();
        step();
        check("gap_hold_busy", b_busy, 32'h1);
        check("gap_no_sv",     b_sv,   32'h0);
        send_pix(8'd3, 8'd200, 8'd3, 1'b0);
        step();
        send_pix(8'd7, 8'd7, 8'd100, 1'b1);
        check("c1_sv",       b_sv,   32'h1);
        check("c1_sad",      b_sad,  32'd19);
        check("c1_idx",      b_idx,  32'd1);
        check("c1_tie_best", b_best, 32'd19);
        check("c1_tie_bidx", b_bidx, 32'd0);

        // Candidate 2 on lane 2: |100-99|+|50-52|+|0-2|+|9-9| = 1+2+2+0 = 5.
        send_pix(8'd100, 8'd0, 8'd99, 1'b0);
        send_pix(8'd50,  8'd0, 8'd52, 1'b0);
        send_pix(8'd0,   8'd0, 8'd2,  1'b0);
        send_pix(8'd9,   8'd0, 8'd9,  1'b0);
        check("c2_sv",       b_sv,   32'h1);
        check("c2_sad",      b_sad,  32'd5);
        check("c2_idx",      b_idx,  32'd2);
        check("c2_best_sad", b_best, 32'd5);
        check("c2_best_idx", b_bidx, 32'd2);
        check("c2_done",     b_done, 32'h1);
        check("c2_busy",     b_busy, 32'h0);
        check("c2_state_done", b_st, 32'h2);
        step();
        check("post_idle_state", b_st,   32'h0);
        check("post_done_pulse", b_done, 32'h0);
        check("post_sv_pulse",   b_sv,   32'h0);
        check("post_sad_held",   b_sad,  32'd5);

        // ---------- dut_c: saturation at ACC_W=8 ----------
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_pix(8'd255, 8'd0, 8'd0, 1'b1);
        end
        check("sat_sv",   c_sv,   32'h1);
        check("sat_sad",  c_sad,  32'hFF);
        check("sat_best", c_best, 32'hFF);
        check("sat_done", c_done, 32'h1);
`ifdef ME_PE_SATFLAG_EN
        check("sat_flag_set", c_sat, 32'h1);
`endif
        step();
        // Same instance without overflow: 4*10 = 40.
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_pix(8'd10, 8'd0, 8'd0, 1'b1);
        end
        check("nosat_sad", c_sad, 32'd40);
`ifdef ME_PE_SATFLAG_EN
        check("sat_flag_clear", c_sat, 32'h0);
`endif
        step();

        // ---------- dut_b: abort in the middle of candidate 1 ----------
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_pix(8'd0, 8'd4, 8'd0, 1'b1);
        end
        check("ab_c0_sad",  b_sad,  32'd16);
        check("ab_c0_best", b_best, 32'd16);
        send_pix(8'd0, 8'd1, 8'd0, 1'b1);
        send_pix(8'd0, 8'd1, 8'd0, 1'b1);
        start_b   = 1'b1;
        R         = 8'd200;
        s1        = 8'd0;
        pix_valid = 1'b1;
        step();
        start_b   = 1'b0;
        pix_valid = 1'b0;
        check("ab_no_sv",     b_sv,   32'h0);
        check("ab_best_init", b_best, 32'hFFFF);
        check("ab_bidx_init", b_bidx, 32'd0);
        check("ab_busy",      b_busy, 32'h1);
        check("ab_sad_held",  b_sad,  32'd16);
        for (int i = 0; i < 3; i++) begin
            send_pix(8'd1, 8'd0, 8'd0, 1'b1);
            check("ab_no_early_sv", b_sv, 32'h0);
        end
        send_pix(8'd1, 8'd0, 8'd0, 1'b1);
        check("ab_new_sv",   b_sv,   32'h1);
        check("ab_new_sad",  b_sad,  32'd4);
        check("ab_new_idx",  b_idx,  32'd0);
        check("ab_new_best", b_best, 32'd4);

        // ---------- asynchronous reset in the middle of ACCUM ----------
        R = 8'h5A;
        send_pix(8'h5A, 8'd0, 8'd0, 1'b1);
        check("ar_pre_busy",  b_busy,  32'h1);
        check("ar_pre_rpipe", b_rpipe, 32'h5A);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_busy",     b_busy,  32'h0);
        check("ar_rpipe",    b_rpipe, 32'h0);
        check("ar_sad",      b_sad,   32'h0);
        check("ar_best_sad", b_best,  32'hFFFF);
        check("ar_best_idx", b_bidx,  32'h0);
        check("ar_idx",      b_idx,   32'h0);
        check("ar_sv",       b_sv,    32'h0);
        check("ar_done",     b_done,  32'h0);
        check("ar_state",    b_st,    32'h0);
        #2;
        reset_n = 1'b1;
        step();
        step();
        check("ar_after_state", b_st, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
